instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch front end of the multicycle LEGv8 core: owns the PC, fetches over a
// req/ack handshake, holds IR for the control unit and computes the next PC.
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] IR,
   output logic        ir_valid,
   input  logic        instr_done,
   input  logic [1:0]  pc_sel,
   input  logic [63:0] imm,
   input  logic [63:0] reg_target,
   input  logic        halt,
   output logic [63:0] PC,
   output logic [63:0] pc_plus4,
   output logic [31:0] retired,
   output logic        halted
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic [31:0] retired_q, retired_d;
   logic [63:0] next_pc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 32'd0;
         ir_valid_q <= 1'b0;
         retired_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         retired_q  <= retired_d;
      end
   end

   // Shifting by 2 drops imm[63:62]; masking keeps BR targets word-aligned.
   always_comb begin
      case (pc_sel)
         2'b01:   next_pc = pc_q + (imm << 2);
         2'b10:   next_pc = reg_target & ~64'd3;
         default: next_pc = pc_q + 64'd4;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      retired_d  = retired_q;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (mem_ack) begin
               ir_d       = mem_rdata;
               ir_valid_d = 1'b1;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (instr_done) begin
               pc_d       = next_pc;
               retired_d  = retired_q + 32'd1;
               ir_valid_d = 1'b0;
               state_d    = halt ? HALT : FETCH;
            end
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   assign mem_req  = (state_q == FETCH);
   assign mem_addr = pc_q;
   assign IR       = ir_q;
   assign ir_valid = ir_valid_q;
   assign PC       = pc_q;
   assign pc_plus4 = pc_q + 64'd4;
   assign retired  = retired_q;
   assign halted   = (state_q == HALT);

endmodule
